// File: rtl/intc_vectored.sv
// Vectored interrupt controller: edge capture, mask, fixed priority, drain/push/vector entry sequencer.
// Entry: pending at T+1, fetch_stall T+2..T+4+DRAIN_CYCLES, vec_valid at T+4+DRAIN_CYCLES.
// No backpressure; fetch_stall holds the pipeline. Define INTC_NESTING_EN for nested entry from SERVICE.
module intc_vectored #(
   parameter int          N_SRC        = 4,
   parameter int          ID_W         = 2,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] VEC_BASE     = 32'h0,
   parameter logic [31:0] VEC_STRIDE   = 32'h2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             rti_done,
   output logic             fetch_stall,
   output logic             push_pc,
   output logic             push_ccr,
   output logic             vec_valid,
   output logic [31:0]      vec_addr,
   output logic [ID_W-1:0]  active_id,
   output logic [N_SRC-1:0] in_service,
   output logic [N_SRC-1:0] pending
);

   localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [N_SRC-1:0] ONE      = N_SRC'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_PUSH_PC, S_PUSH_CCR, S_VECTOR, S_SERVICE
   } state_t;

   state_t           state_q, state_d;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] in_service_q, in_service_d;
   logic [ID_W-1:0]  active_id_q, active_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_SRC-1:0] cand, clr;
   logic [ID_W-1:0]  sel;
   logic             accept;

   // Index 0 is highest priority, so "winner" is always the lowest set bit.
   function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
      lowest_set = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (v[i]) lowest_set = ID_W'(i);
   endfunction

   assign cand = pending_q & mask_q;
   assign sel  = lowest_set(cand);

`ifdef INTC_NESTING_EN
   logic [N_SRC-1:0] isr_after_rti;
   logic             nest_ok;
   assign isr_after_rti = in_service_q & (in_service_q - ONE);
   assign nest_ok       = sel < lowest_set(in_service_q);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         irq_q        <= '0;
         pending_q    <= '0;
         mask_q       <= '0;
         in_service_q <= '0;
         active_id_q  <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         in_service_q <= in_service_d;
         active_id_q  <= active_id_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      active_id_d  = active_id_q;
      in_service_d = in_service_q;
      accept       = 1'b0;
      clr          = '0;
      case (state_q)
         S_IDLE:     accept = (|cand) && (in_service_q == '0);
         S_DRAIN: begin
            if (cnt_q == '0) state_d = S_PUSH_PC;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_PUSH_PC:  state_d = S_PUSH_CCR;
         S_PUSH_CCR: state_d = S_VECTOR;
         S_VECTOR: begin
            state_d      = S_SERVICE;
            in_service_d = in_service_q | (ONE << active_id_q);
         end
         S_SERVICE: begin
`ifdef INTC_NESTING_EN
            // A retiring RTI takes precedence over a nested acceptance in the same cycle.
            if (rti_done) begin
               in_service_d = isr_after_rti;
               if (isr_after_rti == '0) state_d     = S_IDLE;
               else                     active_id_d = lowest_set(isr_after_rti);
            end else begin
               accept = (|cand) && nest_ok;
            end
`else
            if (rti_done) begin
               in_service_d = in_service_q & (in_service_q - ONE);
               state_d      = S_IDLE;
            end
`endif
         end
         default:    state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d     = S_DRAIN;
         cnt_d       = CNT_LOAD;
         active_id_d = sel;
         clr         = ONE << sel;
      end
      // New edge is OR-ed after the clear so a same-cycle set wins.
      pending_d = (pending_q & ~clr) | (irq & ~irq_q);
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   always_comb begin
      fetch_stall = 1'b0;
      push_pc     = 1'b0;
      push_ccr    = 1'b0;
      vec_valid   = 1'b0;
      case (state_q)
         S_DRAIN:    fetch_stall = 1'b1;
         S_PUSH_PC:  begin fetch_stall = 1'b1; push_pc   = 1'b1; end
         S_PUSH_CCR: begin fetch_stall = 1'b1; push_ccr  = 1'b1; end
         S_VECTOR:   begin fetch_stall = 1'b1; vec_valid = 1'b1; end
         default:    ;
      endcase
   end

   assign vec_addr   = VEC_BASE + 32'(active_id_q) * VEC_STRIDE;
   assign active_id  = active_id_q;
   assign in_service = in_service_q;
   assign pending    = pending_q;

endmodule
